// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
//   Bit-serial ripple adder. Two WIDTH-bit operands and a carry-in are
//   accepted over a valid/ready handshake. One sum bit is computed per clock,
//   LSB first, through a single full-adder cell and a carry register. The
//   WIDTH-bit sum and the carry-out are returned over a second valid/ready
//   handshake.
//
//   Optional feature macro: SERIAL_ADDER_OVF_EN
//     When it is defined, an extra output ovf (two's-complement signed
//     overflow) is present and is held alongside sum/cout.
//
// Ports
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous reset, active-low
//   in_valid   in   a, b, cin are valid
//   in_ready   out  block can accept operands (IDLE only)
//   a, b       in   WIDTH-bit operands
//   cin        in   carry-in
//   out_valid  out  sum/cout are valid (DONE only)
//   out_ready  in   consumer accepts the result
//   sum        out  registered (a + b + cin) mod 2^WIDTH
//   cout       out  carry out of bit WIDTH-1
//   ovf        out  signed overflow (only with SERIAL_ADDER_OVF_EN)
//   busy       out  high in RUN or DONE
// ----------------------------------------------------------------------------
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             busy
);

    localparam int unsigned    CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_cout;
    logic [CW-1:0]    r_cnt;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic             w_s;
    logic             w_c;
    logic [WIDTH-1:0] w_sum_next;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_run    = (r_state == S_RUN);
    assign w_last   = w_run && (r_cnt == LAST);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE: if (in_valid)  w_state_next = S_RUN;
            S_RUN:  if (w_last)    w_state_next = S_DONE;
            S_DONE: if (out_ready) w_state_next = S_IDLE;
            default:               w_state_next = S_IDLE;
        endcase
    end

    // Full-adder cell on the current LSBs; the new sum bit enters at the MSB
    // so that after WIDTH shifts bit 0 of the operands lands in sum[0].
    always_comb begin
        w_s        = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
        w_c        = (r_a_sh[0] & r_b_sh[0]) | (r_b_sh[0] & r_carry) |
                     (r_a_sh[0] & r_carry);
        w_sum_next = r_sum >> 1;
        w_sum_next[WIDTH-1] = w_s;
    end

    // Datapath
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_a_sh  <= a;
            r_b_sh  <= b;
            r_carry <= cin;
            r_sum   <= '0;
            r_cnt   <= '0;
        end else if (w_run) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_sum   <= w_sum_next;
            r_carry <= w_c;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_cout <= w_c;
            end
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic r_ovf;

    // On the last bit r_carry is the carry into the MSB and w_c the carry out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_carry ^ w_c;
        end
    end

    assign ovf = r_ovf;
`endif

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
    assign sum       = r_sum;
    assign cout      = r_cout;

endmodule

// File: tb/tb_serial_adder.sv
// ----------------------------------------------------------------------------
// tb_serial_adder
//   Self-checking bench for serial_adder. A WIDTH=8 instance runs a table of
//   directed vectors, handshake/backpressure/reset sequences and random
//   operands. A WIDTH=3 instance runs all operand/carry combinations while
//   its inputs are scrambled during RUN. With SERIAL_ADDER_OVF_EN defined the
//   ovf output of the WIDTH=8 instance is checked as well.
// ----------------------------------------------------------------------------
module tb_serial_adder;

    logic       clk;
    logic       reset_n;

    logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8, busy8;
    logic [7:0] a8, b8, sum8;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf8;
`endif

    logic       in_valid3, in_ready3, cin3, out_valid3, out_ready3, cout3, busy3;
    logic [2:0] a3, b3, sum3;
`ifdef SERIAL_ADDER_OVF_EN
    logic       ovf3;
`endif

    int errors;
    int checks;

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid8),
        .in_ready  (in_ready8),
        .a         (a8),
        .b         (b8),
        .cin       (cin8),
        .out_valid (out_valid8),
        .out_ready (out_ready8),
        .sum       (sum8),
        .cout      (cout8),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf       (ovf8),
`endif
        .busy      (busy8)
    );

    serial_adder #(.WIDTH(3)) u_dut3 (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .a         (a3),
        .b         (b3),
        .cin       (cin3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .sum       (sum3),
        .cout      (cout3),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf       (ovf3),
`endif
        .busy      (busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] s;
        logic       co;
        logic       ov;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: signed overflow from plain integer arithmetic.
    function automatic logic ref_ovf8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int s;
        s = int'($signed(x)) + int'($signed(y)) + int'(c);
        return (s > 127) || (s < -128);
    endfunction

    // Issue one operation to the WIDTH=8 instance and wait for out_valid.
    // Latency counts edges from the accept edge to the one raising out_valid.
    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       output logic [7:0] rs, output logic rc, output logic ro,
                       output int lat);
        int n;
        n = 0;
        while (!in_ready8 && n < 100) begin @(posedge clk); #1; n++; end
        check("op8_ready_timeout", 32'(n < 100), 32'd1);
        a8 = ta; b8 = tb; cin8 = tc; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        lat = 0;
        while (!out_valid8 && lat < 100) begin @(posedge clk); #1; lat++; end
        rs = sum8;
        rc = cout8;
`ifdef SERIAL_ADDER_OVF_EN
        ro = ovf8;
`else
        ro = 1'b0;
`endif
    endtask

    // Complete a result handshake with out_ready already high.
    task automatic finish8(input string tag);
        @(posedge clk); #1;
        check({tag, "_ovalid_drop"}, 32'(out_valid8), 32'd0);
        check({tag, "_iready_back"}, 32'(in_ready8), 32'd1);
    endtask

    task automatic op3(input logic [2:0] ta, input logic [2:0] tb, input logic tc,
                       output logic [3:0] res, output int lat);
        int n;
        n = 0;
        while (!in_ready3 && n < 100) begin @(posedge clk); #1; n++; end
        check("op3_ready_timeout", 32'(n < 100), 32'd1);
        a3 = ta; b3 = tb; cin3 = tc; in_valid3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        lat = 0;
        while (!out_valid3 && lat < 100) begin
            a3 = 3'($urandom); b3 = 3'($urandom); cin3 = 1'($urandom);
            @(posedge clk); #1; lat++;
        end
        res = {cout3, sum3};
    endtask

    vec_t tbl[9];

    initial begin
        logic [7:0] rs;
        logic       rc, ro;
        logic [3:0] r3;
        logic [8:0] full;
        int         lat;

        errors = 0;
        checks = 0;

        tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0};
        tbl[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
        tbl[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[6] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[7] = '{8'h80, 8'hFF, 1'b0, 8'h7F, 1'b1, 1'b1};
        tbl[8] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};

        reset_n = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; cin8 = 1'b0;
        in_valid3 = 1'b0; out_ready3 = 1'b1; a3 = '0; b3 = '0; cin3 = 1'b0;
        #1;
        check("rst_in_ready",  32'(in_ready8),  32'd1);
        check("rst_out_valid", 32'(out_valid8), 32'd0);
        check("rst_busy",      32'(busy8),      32'd0);
        check("rst_sum",       32'(sum8),       32'd0);
        check("rst_cout",      32'(cout8),      32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf",       32'(ovf8),       32'd0);
`endif
        #10;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed table
        for (int i = 0; i < 9; i++) begin
            op8(tbl[i].a, tbl[i].b, tbl[i].cin, rs, rc, ro, lat);
            check($sformatf("tbl%0d_sum", i),  32'(rs),  32'(tbl[i].s));
            check($sformatf("tbl%0d_cout", i), 32'(rc),  32'(tbl[i].co));
            check($sformatf("tbl%0d_lat", i),  32'(lat), 32'd8);
            check($sformatf("tbl%0d_busy", i), 32'(busy8), 32'd1);
`ifdef SERIAL_ADDER_OVF_EN
            check($sformatf("tbl%0d_ovf", i),  32'(ro),  32'(tbl[i].ov));
`endif
            finish8($sformatf("tbl%0d", i));
        end

        // Backpressure: result held, in_valid ignored while DONE
        out_ready8 = 1'b0;
        op8(8'h5A, 8'h3C, 1'b0, rs, rc, ro, lat);
        check("bp_sum", 32'(rs), 32'h96);
        in_valid8 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check($sformatf("bp%0d_valid", k), 32'(out_valid8), 32'd1);
            check($sformatf("bp%0d_sum", k),   32'(sum8),       32'h96);
            check($sformatf("bp%0d_cout", k),  32'(cout8),      32'd0);
            check($sformatf("bp%0d_ready", k), 32'(in_ready8),  32'd0);
        end
        out_ready8 = 1'b1;
        @(posedge clk); #1;
        check("bp_release_ready", 32'(in_ready8),  32'd1);
        check("bp_release_valid", 32'(out_valid8), 32'd0);
        in_valid8 = 1'b0;

        // Reset three edges after accept
        a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrst_busy_before", 32'(busy8), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid8), 32'd0);
        check("midrst_in_ready",  32'(in_ready8),  32'd1);
        check("midrst_busy",      32'(busy8),      32'd0);
        check("midrst_sum",       32'(sum8),       32'd0);
        #2;
        reset_n = 1'b1;
        @(posedge clk); #1;
        op8(8'h10, 8'h20, 1'b0, rs, rc, ro, lat);
        check("postrst_sum",  32'(rs),  32'h30);
        check("postrst_cout", 32'(rc),  32'd0);
        check("postrst_lat",  32'(lat), 32'd8);
        finish8("postrst");

        // Random operands with random backpressure against the reference
        for (int r = 0; r < 40; r++) begin
            logic [7:0] ra, rb;
            logic       rcin;
            int         hold;
            ra = 8'($urandom); rb = 8'($urandom); rcin = 1'($urandom);
            hold = int'($urandom_range(0, 3));
            full = 9'(ra) + 9'(rb) + 9'(rcin);
            out_ready8 = (hold == 0);
            op8(ra, rb, rcin, rs, rc, ro, lat);
            check($sformatf("rnd%0d_sum", r),  32'(rs), 32'(full[7:0]));
            check($sformatf("rnd%0d_cout", r), 32'(rc), 32'(full[8]));
`ifdef SERIAL_ADDER_OVF_EN
            check($sformatf("rnd%0d_ovf", r),  32'(ro), 32'(ref_ovf8(ra, rb, rcin)));
`endif
            for (int h = 0; h < hold; h++) begin
                @(posedge clk); #1;
            end
            check($sformatf("rnd%0d_held", r), 32'(sum8), 32'(full[7:0]));
            out_ready8 = 1'b1;
            finish8($sformatf("rnd%0d", r));
        end

        // Exhaustive WIDTH=3, inputs scrambled during RUN
        for (int ia = 0; ia < 8; ia++) begin
            for (int ib = 0; ib < 8; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    op3(3'(ia), 3'(ib), 1'(ic), r3, lat);
                    check($sformatf("w3_%0d_%0d_%0d", ia, ib, ic), 32'(r3), 32'(ia + ib + ic));
                    if (ia == 0 && ib == 0) begin
                        check($sformatf("w3_lat_%0d", ic), 32'(lat), 32'd3);
                    end
                    @(posedge clk); #1;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
